conv2d: RTL and testbench

CONV2D -- requirements
Module: conv2d

---
 rtl/conv2d.sv | 139 +++++++++++++
 tb/tb_conv2d.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d.sv
// Sequential 2-D convolution engine. It performs one signed multiply-accumulate
// per cycle over a captured input map and kernel, and writes each finished
// output element into its own slot of the result bus.
module conv2d #(
  parameter int IN_CH    = 1,
  parameter int OUT_CH   = 1,
  parameter int K_H      = 3,
  parameter int K_W      = 3,
  parameter int STRIDE_H = 1,
  parameter int STRIDE_W = 1,
  parameter int PAD_H    = 0,
  parameter int PAD_W    = 0,
  parameter int PAD_VAL  = 0,
  parameter int IN_H     = 5,
  parameter int IN_W     = 5,
  parameter int DATA_W   = 8,
  localparam int OUT_H   = (IN_H + 2*PAD_H - K_H) / STRIDE_H + 1,
  localparam int OUT_W   = (IN_W + 2*PAD_W - K_W) / STRIDE_W + 1,
  localparam int ACC_W   = 2*DATA_W + $clog2(IN_CH*K_H*K_W)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [IN_CH*IN_H*IN_W*DATA_W-1:0]       in,
  input  logic [OUT_CH*IN_CH*K_H*K_W*DATA_W-1:0]  kernel,
  output logic [OUT_CH*OUT_H*OUT_W*ACC_W-1:0]     out,
  output logic                                    busy,
  output logic                                    done
);

  localparam int IN_N  = IN_CH*IN_H*IN_W;
  localparam int K_N   = OUT_CH*IN_CH*K_H*K_W;
  localparam int OUT_N = OUT_CH*OUT_H*OUT_W;
  localparam logic signed [DATA_W-1:0] PAD_V = DATA_W'(PAD_VAL);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e state_q, state_d;
  int oc_q, r_q, c_q, ic_q, kr_q, kc_q;
  int oc_d, r_d, c_d, ic_d, kr_d, kc_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [OUT_N*ACC_W-1:0]     out_q, out_d;
  logic [IN_N*DATA_W-1:0]     in_q;
  logic [K_N*DATA_W-1:0]      kern_q;
  logic                       capture;

  int y, x, out_idx;
  logic in_bounds;
  logic signed [DATA_W-1:0]   pix, wgt;
  logic signed [2*DATA_W-1:0] prod;
  logic kc_wrap, kr_wrap, ic_wrap, c_wrap, r_wrap, oc_wrap;

  // Operand fetch for the current tap; positions outside the map read PAD_V.
  always_comb begin
    y         = r_q*STRIDE_H + kr_q - PAD_H;
    x         = c_q*STRIDE_W + kc_q - PAD_W;
    in_bounds = (y >= 0) && (y < IN_H) && (x >= 0) && (x < IN_W);
    pix       = PAD_V;
    if (in_bounds) pix = in_q[(IN_N-1-((ic_q*IN_H + y)*IN_W + x))*DATA_W +: DATA_W];
    wgt       = kern_q[(K_N-1-(((oc_q*IN_CH + ic_q)*K_H + kr_q)*K_W + kc_q))*DATA_W +: DATA_W];
    prod      = pix * wgt;
    sum       = acc_q + ACC_W'(prod);
    out_idx   = (oc_q*OUT_H + r_q)*OUT_W + c_q;
  end

  assign kc_wrap = (kc_q == K_W-1);
  assign kr_wrap = kc_wrap && (kr_q == K_H-1);
  assign ic_wrap = kr_wrap && (ic_q == IN_CH-1);
  assign c_wrap  = ic_wrap && (c_q == OUT_W-1);
  assign r_wrap  = c_wrap && (r_q == OUT_H-1);
  assign oc_wrap = r_wrap && (oc_q == OUT_CH-1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    oc_d = oc_q; r_d = r_q; c_d = c_q; ic_d = ic_q; kr_d = kr_q; kc_d = kc_q;
    acc_d   = acc_q;
    out_d   = out_q;
    capture = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          acc_d   = '0;
          oc_d = 0; r_d = 0; c_d = 0; ic_d = 0; kr_d = 0; kc_d = 0;
          state_d = MAC;
        end
      end
      MAC: begin
        busy  = 1'b1;
        acc_d = sum;
        kc_d  = kc_wrap ? 0 : kc_q + 1;
        if (kc_wrap) kr_d = kr_wrap ? 0 : kr_q + 1;
        if (kr_wrap) ic_d = ic_wrap ? 0 : ic_q + 1;
        if (ic_wrap) begin
          c_d   = c_wrap ? 0 : c_q + 1;
          out_d[(OUT_N-1-out_idx)*ACC_W +: ACC_W] = sum;
          acc_d = '0;
        end
        if (c_wrap) r_d  = r_wrap ? 0 : r_q + 1;
        if (r_wrap) oc_d = oc_wrap ? 0 : oc_q + 1;
        if (oc_wrap) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oc_q <= 0; r_q <= 0; c_q <= 0; ic_q <= 0; kr_q <= 0; kc_q <= 0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      oc_q <= oc_d; r_q <= r_d; c_q <= c_d; ic_q <= ic_d; kr_q <= kr_d; kc_q <= kc_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // NOTE: the operand copies are not reset; they are always loaded before a job reads them.
  always_ff @(posedge clk) begin
    if (capture) begin
      in_q   <= in;
      kern_q <= kernel;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_conv2d.sv
// Randomized self-checking bench for conv2d: a timeline/reference model checks the
// default instance every cycle; stride-2 and pad-1 instances are checked per job.
module tb_conv2d;

  localparam int T_D = 81;
  localparam int T_S = 36;
  localparam int T_P = 225;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_d = 1'b0, start_s = 1'b0, start_p = 1'b0;
  logic [199:0] in_bus = '0;
  logic [71:0]  kern_bus = '0;
  logic [179:0] out_d;
  logic [79:0]  out_s;
  logic [499:0] out_p;
  logic busy_d, done_d, busy_s, done_s, busy_p, done_p;

  int n_checks = 0;
  int n_errors = 0;

  int lit_ones[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
  int lit_ctr[9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
  int lit_s2[4]   = '{63, 81, 153, 171};

  always #5 clk = ~clk;

  conv2d u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_d), .in(in_bus), .kernel(kern_bus),
    .out(out_d), .busy(busy_d), .done(done_d)
  );

  conv2d #(.STRIDE_H(2), .STRIDE_W(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in(in_bus), .kernel(kern_bus),
    .out(out_s), .busy(busy_s), .done(done_s)
  );

  conv2d #(.PAD_H(1), .PAD_W(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(start_p), .in(in_bus), .kernel(kern_bus),
    .out(out_p), .busy(busy_p), .done(done_p)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [499:0] act, input logic [499:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: direct evaluation of the convolution sum on a 5x5 map, 3x3 kernel.
  function automatic int xel(input logic [199:0] xb, input int r, input int c, input int pv);
    logic signed [7:0] t;
    if (r < 0 || r >= 5 || c < 0 || c >= 5) return pv;
    t = xb[(24-(r*5+c))*8 +: 8];
    return int'(t);
  endfunction

  function automatic int wel(input logic [71:0] wb, input int kr, input int kc);
    logic signed [7:0] t;
    t = wb[(8-(kr*3+kc))*8 +: 8];
    return int'(t);
  endfunction

  function automatic int oel(input logic [499:0] ob, input int n, input int e);
    logic signed [19:0] t;
    t = ob[(n-1-e)*20 +: 20];
    return int'(t);
  endfunction

  function automatic void conv_ref(input logic [199:0] xb, input logic [71:0] wb,
                                   input int s, input int p, input int pv,
                                   output int res[25], output int n);
    int oh;
    oh = (5 + 2*p - 3) / s + 1;
    n  = oh*oh;
    for (int e = 0; e < 25; e++) res[e] = 0;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < oh; c++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            res[r*oh+c] += xel(xb, r*s+kr-p, c*s+kc-p, pv) * wel(wb, kr, kc);
  endfunction

  function automatic logic [179:0] pack9(input int res[25]);
    logic [179:0] v;
    v = '0;
    for (int e = 0; e < 9; e++) v[(8-e)*20 +: 20] = res[e][19:0];
    return v;
  endfunction

  // Timeline model of the default instance: phase 0 idle, 1..T_D computing, T_D+1 done.
  int ph = 0;
  logic [179:0] exp_out = '0;
  logic [179:0] pend = '0;

  always @(posedge clk or negedge rst_n) begin
    int res[25];
    int n;
    if (!rst_n) begin
      ph = 0;
      exp_out = '0;
    end else if (ph == 0) begin
      if (start_d) begin
        conv_ref(in_bus, kern_bus, 1, 0, 0, res, n);
        pend = pack9(res);
        ph = 1;
      end
    end else if (ph <= T_D) begin
      ph++;
      if (ph == T_D+1) exp_out = pend;
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("mon_busy", int'(busy_d), (ph >= 1 && ph <= T_D) ? 1 : 0);
      check("mon_done", int'(done_d), (ph == T_D+1) ? 1 : 0);
      if (ph == 0 || ph == T_D+1) check_vec("mon_out", out_d, exp_out);
    end
  end

  task automatic load_seq(input int kind);
    for (int e = 0; e < 25; e++) in_bus[(24-e)*8 +: 8] = 8'(e+1);
    for (int k = 0; k < 9; k++)
      kern_bus[(8-k)*8 +: 8] = (kind == 0) ? 8'd1 : (k != 4) ? 8'd0 : (kind == 1) ? 8'd1 : 8'hFF;
  endtask

  task automatic load_rand();
    for (int e = 0; e < 25; e++) in_bus[(24-e)*8 +: 8] = 8'($urandom);
    for (int k = 0; k < 9; k++) kern_bus[(8-k)*8 +: 8] = 8'($urandom);
  endtask

  task automatic job_d(output int lat);
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    lat = 1;
    while (!done_d && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic cmp_default(input logic [199:0] xb, input logic [71:0] wb, input string tag);
    int res[25];
    int n;
    conv_ref(xb, wb, 1, 0, 0, res, n);
    for (int e = 0; e < n; e++) check($sformatf("%s[%0d]", tag, e), oel(out_d, 9, e), res[e]);
  endtask

  task automatic pin_default(input int lit[9], input int sgn, input string tag);
    int res[25];
    int n;
    conv_ref(in_bus, kern_bus, 1, 0, 0, res, n);
    for (int e = 0; e < 9; e++) begin
      check($sformatf("%s_model[%0d]", tag, e), res[e], sgn*lit[e]);
      check($sformatf("%s_dut[%0d]", tag, e), oel(out_d, 9, e), sgn*lit[e]);
    end
  endtask

  task automatic run_variants();
    int cyc = 1;
    int lat_s = 0, lat_p = 0;
    @(negedge clk) begin start_s = 1'b1; start_p = 1'b1; end
    @(negedge clk) begin start_s = 1'b0; start_p = 1'b0; end
    while ((lat_s == 0 || lat_p == 0) && cyc < 400) begin
      if (done_s && lat_s == 0) lat_s = cyc;
      if (done_p && lat_p == 0) lat_p = cyc;
      if (lat_s == 0 || lat_p == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("s2_latency", lat_s, T_S+1);
    check("p1_latency", lat_p, T_P+1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((busy_d || done_d) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_reached", int'(busy_d || done_d), 0);
  endtask

  initial begin
    int lat, n, nd;
    int res[25];
    logic [199:0] xb0;
    logic [71:0]  wb0;

    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy_d), 0);
    check("rst_done", int'(done_d), 0);
    check_vec("rst_out", out_d, '0);
    @(negedge clk) rst_n = 1'b1;

    // Directed jobs on the default instance.
    load_seq(0);
    job_d(lat);
    check("ones_latency", lat, T_D+1);
    pin_default(lit_ones, 1, "ones");

    load_seq(1);
    job_d(lat);
    check("ctr_latency", lat, T_D+1);
    pin_default(lit_ctr, 1, "ctr");

    load_seq(2);
    job_d(lat);
    pin_default(lit_ctr, -1, "neg");
    check("neg_raw", int'(out_d[179:160]), 32'h000F_FFF9);

    // Stride-2 and pad-1 variants: literal results, then random data against the model.
    load_seq(0);
    run_variants();
    for (int e = 0; e < 4; e++) check($sformatf("s2_lit[%0d]", e), oel(out_s, 4, e), lit_s2[e]);
    check("p1_corner", oel(out_p, 25, 0), 16);
    check("p1_centre", oel(out_p, 25, 12), 117);
    conv_ref(in_bus, kern_bus, 1, 1, 0, res, n);
    check("p1_model_corner", res[0], 16);
    check("p1_model_size", n, 25);

    for (int j = 0; j < 2; j++) begin
      load_rand();
      run_variants();
      conv_ref(in_bus, kern_bus, 2, 0, 0, res, n);
      for (int e = 0; e < n; e++) check($sformatf("s2_rand[%0d]", e), oel(out_s, 4, e), res[e]);
      conv_ref(in_bus, kern_bus, 1, 1, 0, res, n);
      for (int e = 0; e < n; e++) check($sformatf("p1_rand[%0d]", e), oel(out_p, 25, e), res[e]);
    end

    // Random jobs on the default instance.
    for (int j = 0; j < 6; j++) begin
      load_rand();
      xb0 = in_bus;
      wb0 = kern_bus;
      job_d(lat);
      check("rand_latency", lat, T_D+1);
      cmp_default(xb0, wb0, "rand");
    end

    // Start pulsed while busy, with operands changed mid-job.
    load_rand();
    xb0 = in_bus;
    wb0 = kern_bus;
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    repeat (20) @(negedge clk);
    start_d = 1'b1;
    load_rand();
    @(negedge clk) start_d = 1'b0;
    lat = 0;
    while (!done_d && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_done_seen", int'(done_d), 1);
    cmp_default(xb0, wb0, "busy_start");
    repeat (5) @(negedge clk);
    cmp_default(xb0, wb0, "idle_hold");

    // Start held high: back-to-back jobs, one idle cycle between them.
    load_rand();
    nd = 0;
    @(negedge clk) start_d = 1'b1;
    repeat (249) begin
      @(negedge clk);
      if (done_d) nd++;
    end
    start_d = 1'b0;
    check("b2b_done_count", nd, 3);
    wait_idle();

    // Reset in the middle of a job aborts it.
    load_seq(0);
    @(negedge clk) start_d = 1'b1;
    @(negedge clk) start_d = 1'b0;
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy_d), 0);
    check("abort_done", int'(done_d), 0);
    check_vec("abort_out", out_d, '0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_d) nd++;
    end
    check("abort_no_done", nd, 0);
    check_vec("abort_out_hold", out_d, '0);

    job_d(lat);
    check("post_reset_latency", lat, T_D+1);
    pin_default(lit_ones, 1, "post_reset");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
